// File: rtl/buttons_debounce.sv
// buttons_debounce: sync+debounce OR of five keys, press/release ticks, key code; BUTTONS_SYNC_EN adds 2-flop synchronizer; ports clk, reset(active-low sync), sw[4:0], sw_clear, pos_tick, neg_tick, kcode[2:0]
module buttons_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sw,
  output logic       sw_clear,
  output logic       pos_tick,
  output logic       neg_tick,
  output logic [2:0] kcode
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES);
  localparam logic [CW-1:0] C1 = CW'(1);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [4:0] r;
  logic any, done;
  logic [2:0] code;
`ifdef BUTTONS_SYNC_EN
  logic [4:0] s0, s1;
  always_ff @(posedge clk)
    if (!reset) {s1, s0} <= '0;
    else {s1, s0} <= {s0, sw};
  assign r = s1;
`else
  assign r = sw;
`endif
  assign any = |r;
  assign done = count >= CMAX - C1;
  always_comb code = r[0] ? 3'd1 : r[1] ? 3'd2 : r[2] ? 3'd3 : r[3] ? 3'd4 : r[4] ? 3'd5 : 3'd0;
  always_ff @(posedge clk)
    if (!reset) begin
      state    <= ZERO;
      count    <= '0;
      sw_clear <= 1'b0;
      pos_tick <= 1'b0;
      neg_tick <= 1'b0;
      kcode    <= 3'd0;
    end else begin
      pos_tick <= 1'b0;
      neg_tick <= 1'b0;
      case (state)
        ZERO:
          if (any) begin
            state <= WAIT1;
            count <= C1;
          end
        WAIT1:
          if (!any) state <= ZERO;
          else if (done) begin
            state    <= ONE;
            count    <= CMAX;
            pos_tick <= 1'b1;
            sw_clear <= 1'b1;
            kcode    <= code;
          end else count <= count + C1;
        ONE:
          if (!any) begin
            state <= WAIT0;
            count <= C1;
          end
        WAIT0:
          if (any) state <= ONE;
          else if (done) begin
            state    <= ZERO;
            count    <= CMAX;
            neg_tick <= 1'b1;
            sw_clear <= 1'b0;
          end else count <= count + C1;
      endcase
    end
endmodule

// File: tb/tb_buttons_debounce.sv
// tb_buttons_debounce: directed self-checking bench for buttons_debounce
module tb_buttons_debounce;
  localparam int DB = 1000;
`ifdef BUTTONS_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] sw = '0;
  logic sw_clear, pos_tick, neg_tick;
  logic [2:0] kcode;
  int checks = 0, failures = 0, cyc = 0;
  int npos = 0, nneg = 0, both = 0, pos_cyc = -1, neg_cyc = -1;
  int pos_k = 0, pos_clr = 0, neg_clr = 1, neg_k = 0;
  int c0, p0, n0;
  buttons_debounce #(.DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .sw(sw), .sw_clear(sw_clear),
    .pos_tick(pos_tick), .neg_tick(neg_tick), .kcode(kcode)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pos_tick) begin
      npos <= npos + 1;
      pos_cyc <= cyc;
      pos_k <= int'(kcode);
      pos_clr <= int'(sw_clear);
    end
    if (neg_tick) begin
      nneg <= nneg + 1;
      neg_cyc <= cyc;
      neg_k <= int'(kcode);
      neg_clr <= int'(sw_clear);
    end
    if (pos_tick && neg_tick) both <= both + 1;
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic mark;
    p0 = npos;
    n0 = nneg;
  endtask
  initial begin
    step(5);
    check("rst_clear", int'(sw_clear), 0);
    check("rst_pos", int'(pos_tick), 0);
    check("rst_neg", int'(neg_tick), 0);
    check("rst_kcode", int'(kcode), 0);
    reset = 1'b1;
    step(20);
    check("idle_ticks", npos + nneg, 0);
    mark();
    sw = 5'b00001;
    c0 = cyc;
    step(1500);
    check("k1_pos_cnt", npos - p0, 1);
    check("k1_pos_lat", pos_cyc - c0, DB + S);
    check("k1_pos_kcode", pos_k, 1);
    check("k1_pos_clear", pos_clr, 1);
    sw = 5'b00000;
    c0 = cyc;
    step(1500);
    check("k1_neg_cnt", nneg - n0, 1);
    check("k1_neg_lat", neg_cyc - c0, DB + S);
    check("k1_neg_clear", neg_clr, 0);
    check("k1_kcode_hold", int'(kcode), 1);
    mark();
    for (int i = 0; i < 5; i++) begin
      sw = (i % 2 == 0) ? 5'b00010 : 5'b00000;
      c0 = cyc;
      step(i == 4 ? 1500 : 25);
    end
    check("gl_pos_cnt", npos - p0, 1);
    check("gl_pos_lat", pos_cyc - c0, DB + S);
    check("gl_kcode", pos_k, 2);
    for (int i = 0; i < 5; i++) begin
      sw = (i % 2 == 0) ? 5'b00000 : 5'b00010;
      c0 = cyc;
      step(i == 4 ? 1500 : 25);
    end
    check("gl_neg_cnt", nneg - n0, 1);
    check("gl_neg_lat", neg_cyc - c0, DB + S);
    check("gl_total_pos", npos - p0, 1);
    mark();
    sw = 5'b00100;
    step(250);
    check("short_clear_mid", int'(sw_clear), 0);
    step(250);
    sw = 5'b00000;
    step(1500);
    check("short_ticks", (npos - p0) + (nneg - n0), 0);
    check("short_clear", int'(sw_clear), 0);
    sw = 5'b00100;
    step(2250);
    sw = 5'b00000;
    step(1500);
    check("long_pos_cnt", npos - p0, 1);
    check("long_neg_cnt", nneg - n0, 1);
    check("long_kcode", pos_k, 3);
    mark();
    sw = 5'b01000;
    step(1500);
    sw = 5'b11000;
    step(1500);
    check("multi_clear", int'(sw_clear), 1);
    sw = 5'b00000;
    step(1500);
    check("multi_pos_cnt", npos - p0, 1);
    check("multi_neg_cnt", nneg - n0, 1);
    check("multi_kcode", int'(kcode), 4);
    mark();
    sw = 5'b10100;
    step(1500);
    sw = 5'b00000;
    step(1500);
    check("simul_kcode", pos_k, 3);
    check("simul_cnt", (npos - p0) + (nneg - n0), 2);
    mark();
    sw = 5'b00001;
    step(500);
    check("pre_rst_pos", npos - p0, 0);
    reset = 1'b0;
    c0 = cyc;
    step(1);
    reset = 1'b1;
    check("mid_rst_kcode", int'(kcode), 0);
    check("mid_rst_clear", int'(sw_clear), 0);
    step(1500);
    check("rst_pos_cnt", npos - p0, 1);
    check("rst_pos_lat", pos_cyc - c0, 1 + DB + S);
    check("rst_pos_kcode", pos_k, 1);
    sw = 5'b00000;
    step(1500);
    check("rst_neg_cnt", nneg - n0, 1);
    check("both_ticks", both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
